// File: rtl/fault_injector_if.sv
// Campaign config, status and replica buses between the fault injector and its driver.
interface fault_injector_if #(
   parameter int WIDTH = 32,
   parameter int NREP  = 9,
   parameter int CNTW  = 16
);
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [3:0]            cfg_replica;
   logic [4:0]            cfg_bit;
   logic [1:0]            cfg_mode;
   logic [CNTW-1:0]       cfg_delay;
   logic [CNTW-1:0]       cfg_duration;
   logic                  abort;
   logic [NREP*WIDTH-1:0] rep_in;
   logic [NREP*WIDTH-1:0] rep_out;
   logic                  inj_active;
   logic                  inj_done;
   logic                  cfg_err;
   logic [7:0]            inj_count;

   modport master (
      output cfg_valid, cfg_replica, cfg_bit, cfg_mode, cfg_delay, cfg_duration, abort, rep_in,
      input  cfg_ready, rep_out, inj_active, inj_done, cfg_err, inj_count
   );

   modport slave (
      input  cfg_valid, cfg_replica, cfg_bit, cfg_mode, cfg_delay, cfg_duration, abort, rep_in,
      output cfg_ready, rep_out, inj_active, inj_done, cfg_err, inj_count
   );
endinterface

// File: rtl/fault_injector.sv
// Corrupts one replica word per campaign; fault starts 1+delay cycles after accept, rep_out is combinational.
// Backpressure: cfg_ready only in IDLE/DONE and never while abort is high.
module fault_injector #(
   parameter int WIDTH = 32,
   parameter int NREP  = 9,
   parameter int CNTW  = 16
) (
   input logic             clk,
   input logic             reset,
   fault_injector_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ARMED, INJECT, DONE} state_t;

   typedef struct packed {
      logic [3:0]      replica;
      logic [4:0]      bit_idx;
      logic [1:0]      mode;
      logic [CNTW-1:0] duration;
   } cfg_t;

   state_t          state_q, state_d;
   cfg_t            cfg_q, cfg_d;
   logic [CNTW-1:0] dcnt_q, dcnt_d;
   logic [CNTW-1:0] rcnt_q, rcnt_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            cfg_ready;
   logic            accept;
   logic            bad_idx;
   logic            inj_active;
   logic [WIDTH-1:0] bit_mask;

   assign inj_active = (state_q == INJECT);
   assign cfg_ready  = ((state_q == IDLE) || (state_q == DONE)) && !bus.abort;
   assign accept     = bus.cfg_valid && cfg_ready;
   assign bad_idx    = int'(bus.cfg_replica) >= NREP;

   assign bus.cfg_ready  = cfg_ready;
   assign bus.inj_active = inj_active;
   assign bus.inj_done   = (state_q == DONE);
   assign bus.cfg_err    = err_q;
   assign bus.inj_count  = cnt_q;

   always_comb begin
      state_d = state_q;
      cfg_d   = cfg_q;
      dcnt_d  = dcnt_q;
      rcnt_d  = rcnt_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      if (bus.abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  if (bad_idx) begin
                     err_d = 1'b1;
                  end else begin
                     cfg_d.replica  = bus.cfg_replica;
                     cfg_d.bit_idx  = bus.cfg_bit;
                     cfg_d.mode     = bus.cfg_mode;
                     cfg_d.duration = bus.cfg_duration;
                     dcnt_d         = bus.cfg_delay;
                     state_d        = ARMED;
                  end
               end
            end
            ARMED: begin
               if (dcnt_q == '0) begin
                  state_d = INJECT;
                  rcnt_d  = cfg_q.duration;
                  if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
               end else begin
                  dcnt_d = dcnt_q - CNTW'(1);
               end
            end
            INJECT: begin
               // Zero duration means permanent: only abort or reset ends it.
               if (cfg_q.duration != '0) begin
                  if (rcnt_q <= CNTW'(1)) begin
                     state_d = DONE;
                     rcnt_d  = '0;
                  end else begin
                     rcnt_d = rcnt_q - CNTW'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cfg_q   <= '0;
         dcnt_q  <= '0;
         rcnt_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cfg_q   <= cfg_d;
         dcnt_q  <= dcnt_d;
         rcnt_q  <= rcnt_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // An out-of-range bit index leaves the mask empty, so modes 00-10 alter nothing.
   always_comb begin
      bit_mask = '0;
      for (int i = 0; i < WIDTH; i++) bit_mask[i] = (int'(cfg_q.bit_idx) == i);
   end

   always_comb begin
      bus.rep_out = bus.rep_in;
      for (int r = 0; r < NREP; r++) begin
         if (inj_active && (int'(cfg_q.replica) == r)) begin
            case (cfg_q.mode)
               2'b00:   bus.rep_out[r*WIDTH +: WIDTH] = bus.rep_in[r*WIDTH +: WIDTH] ^ bit_mask;
               2'b01:   bus.rep_out[r*WIDTH +: WIDTH] = bus.rep_in[r*WIDTH +: WIDTH] & ~bit_mask;
               2'b10:   bus.rep_out[r*WIDTH +: WIDTH] = bus.rep_in[r*WIDTH +: WIDTH] | bit_mask;
               default: bus.rep_out[r*WIDTH +: WIDTH] = ~bus.rep_in[r*WIDTH +: WIDTH];
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fault_injector.sv
// Scoreboard bench: campaign timeline model predicts every cycle, a negedge monitor compares.
module tb_fault_injector;
   localparam int WIDTH = 32;
   localparam int NREP  = 9;
   localparam int CNTW  = 16;
   localparam int BUSW  = WIDTH * NREP;

   typedef struct {
      logic [BUSW-1:0] rep;
      logic            rdy;
      logic            act;
      logic            done;
      logic            err;
      logic [7:0]      cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fault_injector_if #(.WIDTH(WIDTH), .NREP(NREP), .CNTW(CNTW)) bus ();
   fault_injector #(.WIDTH(WIDTH), .NREP(NREP), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;
   exp_t sbq[$];

   // Campaign model: absolute edge numbers for fault start and end.
   int t = 0;
   bit m_camp = 0;
   bit m_perm = 0;
   int m_start, m_end, m_rep, m_bit, m_mode;
   int m_cnt = 0;
   bit m_err = 0;

   function automatic void chk(input string name, input logic [BUSW-1:0] act, input logic [BUSW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
      end
   endfunction

   function automatic logic [WIDTH-1:0] corrupt(input logic [WIDTH-1:0] w, input int mode, input int b);
      logic [WIDTH-1:0] one;
      one = (b < WIDTH) ? (WIDTH'(1) << b) : '0;
      case (mode)
         0:       return w ^ one;
         1:       return w & ~one;
         2:       return w | one;
         default: return ~w;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] vote(input logic [BUSW-1:0] v);
      logic [WIDTH-1:0] res;
      for (int i = 0; i < WIDTH; i++) begin
         int ones;
         ones = 0;
         for (int r = 0; r < NREP; r++) ones += int'(v[r*WIDTH + i]);
         res[i] = (ones > NREP / 2);
      end
      return res;
   endfunction

   function automatic logic [WIDTH-1:0] word_of(input logic [BUSW-1:0] v, input int r);
      return v[r*WIDTH +: WIDTH];
   endfunction

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("rep_out",    bus.rep_out,    e.rep);
         chk("cfg_ready",  BUSW'(bus.cfg_ready),  BUSW'(e.rdy));
         chk("inj_active", BUSW'(bus.inj_active), BUSW'(e.act));
         chk("inj_done",   BUSW'(bus.inj_done),   BUSW'(e.done));
         chk("cfg_err",    BUSW'(bus.cfg_err),    BUSW'(e.err));
         chk("inj_count",  BUSW'(bus.inj_count),  BUSW'(e.cnt));
      end
   end

   // Called just after a rising edge: drives inputs, predicts this cycle, then models the next edge.
   task automatic cycle(input bit v, input int rp, input int b, input int m, input int d,
                        input int du, input bit ab, input logic [BUSW-1:0] rin);
      exp_t e;
      bit done, act;
      bus.cfg_valid    = v;
      bus.cfg_replica  = 4'(rp);
      bus.cfg_bit      = 5'(b);
      bus.cfg_mode     = 2'(m);
      bus.cfg_delay    = CNTW'(d);
      bus.cfg_duration = CNTW'(du);
      bus.abort        = ab;
      bus.rep_in       = rin;
      done  = m_camp && !m_perm && (t >= m_end);
      act   = m_camp && (t >= m_start) && (m_perm || t < m_end);
      e.rdy = (!m_camp || done) && !ab;
      e.act = act;
      e.done = done;
      e.err = m_err;
      e.cnt = 8'(m_cnt);
      e.rep = rin;
      if (act) e.rep[m_rep*WIDTH +: WIDTH] = corrupt(rin[m_rep*WIDTH +: WIDTH], m_mode, m_bit);
      sbq.push_back(e);
      @(posedge clk);
      t++;
      m_err = 0;
      if (ab) begin
         m_camp = 0;
      end else if (v && e.rdy) begin
         if (rp >= NREP) begin
            m_err = 1;
         end else begin
            m_camp  = 1;
            m_start = t + 1 + d;
            m_end   = m_start + du;
            m_perm  = (du == 0);
            m_rep   = rp;
            m_bit   = b;
            m_mode  = m;
         end
      end
      if (m_camp && t == m_start && m_cnt < 255) m_cnt++;
      #1;
   endtask

   task automatic idle(input logic [BUSW-1:0] rin);
      cycle(0, 0, 0, 0, 0, 0, 0, rin);
   endtask

   logic [BUSW-1:0] pat_a5, pat_zero, rin;
   logic [WIDTH-1:0] a, b, res;

   initial begin
      pat_a5   = {NREP{32'hA5A5A5A5}};
      pat_zero = '0;
      reset = 1'b1;
      bus.cfg_valid = 0; bus.cfg_replica = '0; bus.cfg_bit = '0; bus.cfg_mode = '0;
      bus.cfg_delay = '0; bus.cfg_duration = '0; bus.abort = 0; bus.rep_in = pat_a5;
      #2;
      chk("reset_rep_out",   bus.rep_out, pat_a5);
      chk("reset_cfg_ready", BUSW'(bus.cfg_ready),  BUSW'(1));
      chk("reset_count",     BUSW'(bus.inj_count),  BUSW'(0));
      chk("reset_active",    BUSW'(bus.inj_active), BUSW'(0));
      chk("reset_done",      BUSW'(bus.inj_done),   BUSW'(0));
      #6 reset = 1'b0;
      @(posedge clk); #1;

      // Flip bit 0 of replica 3, delay 2, duration 3.
      cycle(1, 3, 0, 0, 2, 3, 0, pat_a5);
      for (int i = 1; i <= 6; i++) begin
         idle(pat_a5);
         if (i == 3) chk("flip_rep3", BUSW'(word_of(bus.rep_out, 3)), BUSW'(32'hA5A5A5A4));
         if (i == 6) begin
            chk("flip_done",     BUSW'(bus.inj_done),  BUSW'(1));
            chk("flip_count",    BUSW'(bus.inj_count), BUSW'(1));
            chk("flip_restored", BUSW'(word_of(bus.rep_out, 3)), BUSW'(32'hA5A5A5A5));
         end
      end

      // Permanent word invert on replica 8, ended by abort.
      cycle(1, 8, 0, 3, 0, 0, 0, pat_a5);
      for (int i = 0; i < 3; i++) idle(pat_a5);
      chk("invert_rep8", BUSW'(word_of(bus.rep_out, 8)), BUSW'(32'h5A5A5A5A));
      cycle(0, 0, 0, 0, 0, 0, 1, pat_a5);
      chk("abort_rep_out", bus.rep_out, pat_a5);
      chk("abort_done",    BUSW'(bus.inj_done),   BUSW'(0));
      chk("abort_active",  BUSW'(bus.inj_active), BUSW'(0));

      // Out-of-range replica is rejected with a one-cycle error pulse.
      cycle(1, 9, 0, 0, 0, 2, 0, pat_a5);
      chk("reject_err",   BUSW'(bus.cfg_err),   BUSW'(1));
      chk("reject_count", BUSW'(bus.inj_count), BUSW'(2));
      idle(pat_a5);
      chk("reject_err_clear", BUSW'(bus.cfg_err), BUSW'(0));

      // Abort beats a simultaneous request.
      cycle(1, 2, 0, 0, 0, 1, 1, pat_a5);
      idle(pat_a5);
      idle(pat_a5);
      chk("abort_win_active", BUSW'(bus.inj_active), BUSW'(0));
      chk("abort_win_count",  BUSW'(bus.inj_count),  BUSW'(2));

      // Reset during a stuck-at-1 fault on bit 31 removes it before the next edge.
      cycle(1, 0, 31, 2, 0, 0, 0, pat_zero);
      idle(pat_zero);
      chk("stuck1_rep0", BUSW'(word_of(bus.rep_out, 0)), BUSW'(32'h80000000));
      #1 reset = 1'b1;
      #1;
      chk("rst_mid_rep_out", bus.rep_out, pat_zero);
      chk("rst_mid_active",  BUSW'(bus.inj_active), BUSW'(0));
      chk("rst_mid_count",   BUSW'(bus.inj_count),  BUSW'(0));
      m_camp = 0; m_cnt = 0; m_err = 0;
      bus.cfg_valid = 0;
      #2 reset = 1'b0;
      @(posedge clk); #1;

      // Identical ALU results on all replicas with one stuck-at fault: the majority is unaffected.
      cycle(1, $urandom_range(0, NREP-1), $urandom_range(0, 31), $urandom_range(1, 2), 0, 0, 0, pat_zero);
      for (int i = 0; i < 20; i++) begin
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 3))
            0:       res = a + b;
            1:       res = a - b;
            2:       res = a ^ b;
            default: res = a & b;
         endcase
         idle({NREP{res}});
         chk("voter_out", BUSW'(vote(bus.rep_out)), BUSW'(res));
      end
      cycle(0, 0, 0, 0, 0, 0, 1, pat_zero);

      // Randomized campaigns, aborts and replica data.
      for (int i = 0; i < 400; i++) begin
         for (int r = 0; r < NREP; r++) rin[r*WIDTH +: WIDTH] = $urandom();
         cycle(($urandom_range(0, 9) < 3), $urandom_range(0, 10), $urandom_range(0, 31),
               $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
               ($urandom_range(0, 19) == 0), rin);
      end

      idle(pat_zero);
      @(negedge clk); #1;
      chk("scoreboard_drained", BUSW'(sbq.size()), BUSW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
